// File: rtl/bin_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// bin_ram_arbiter_if
//
// Purpose:
//    Bundles the two requester command channels and the shared completion
//    signals of the RAM arbiter into one interface.
//
// Parameters:
//    AW   word address width (array depth is 2**AW words)
//    DW   data word width in bits
//
// Signals:
//    req0, req1     request from requester 0 / 1
//    we0, we1       1 = write, 0 = read; held with the request
//    addr0, addr1   word address; held with the request
//    din0, din1     write data; held with the request
//    ack0, ack1     one-cycle completion pulse to the served requester
//    dout           registered read data, valid while the matching ack is high
//    busy           arbiter is not idle
//
// Modports:
//    master   requester side (drives commands, observes completion)
//    slave    arbiter side (observes commands, drives completion)
// ----------------------------------------------------------------------------
interface bin_ram_arbiter_if #(
    parameter int AW = 2,
    parameter int DW = 4
);

    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] dout;
    logic          busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, din0, din1,
        input  ack0, ack1, dout, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, din0, din1,
        output ack0, ack1, dout, busy
    );

endinterface

// File: rtl/bin_ram_arbiter.sv
// ----------------------------------------------------------------------------
// bin_ram_arbiter
//
// Purpose:
//    Two-port arbiter and sequencer in front of a small single-ported,
//    word-organised RAM. A winning request is latched in IDLE, the array is
//    accessed once in ACCESS (read or write), and a one-cycle acknowledge is
//    returned to the winner in DONE together with registered read data.
//
// Ports:
//    clk_i   rising-edge clock
//    rst_i   synchronous, active-high reset (array contents are preserved)
//    bus     bin_ram_arbiter_if.slave: requester commands in, ack/dout/busy out
//
// Parameters:
//    AW      word address width, array depth 2**AW
//    DW      data width
//
// Build options:
//    RAM_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests are granted
//                            to the requester not served last; otherwise
//                            requester 0 has fixed priority.
// ----------------------------------------------------------------------------
module bin_ram_arbiter #(
    parameter int AW = 2,
    parameter int DW = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bin_ram_arbiter_if.slave    bus
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          last_q, last_d;
    logic [DW-1:0] dout_q, dout_d;

    logic [DW-1:0] mem [DEPTH];

    logic [DEPTH-1:0] cs;
    logic             rStrobe;
    logic             wStrobe;
    logic [DW-1:0]    readWord;
    logic             anyReq;
    logic             grantSel;
    logic             ack0;
    logic             ack1;

    // Pick the requester to serve when the arbiter is idle. A lone request
    // always wins; a tie is broken either by fairness (the side not served
    // last) or by fixed priority to requester 0. LAST is tracked in both
    // builds so the two variants differ only in this decision.
    always_comb begin
        anyReq   = bus.req0 | bus.req1;
        grantSel = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            grantSel = ~last_q;
`else
            grantSel = 1'b0;
`endif
        end else if (bus.req1) begin
            grantSel = 1'b1;
        end
    end

    // The read path is an AND-OR of every word gated by its chip select,
    // mirroring how the cell array shares one read bus among all words.
    always_comb begin
        readWord = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cs[i] && rStrobe) begin
                readWord = readWord | mem[i];
            end
        end
    end

    // Next-state and strobe logic. Everything holds by default; the command
    // registers only load in IDLE, which is what makes requester inputs
    // irrelevant once a transaction is under way. ACK is a pure function of
    // the DONE state and the latched winner.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        last_d  = last_q;
        dout_d  = dout_q;
        cs      = '0;
        rStrobe = 1'b0;
        wStrobe = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (anyReq) begin
                    sel_d   = grantSel;
                    last_d  = grantSel;
                    we_d    = grantSel ? bus.we1   : bus.we0;
                    addr_d  = grantSel ? bus.addr1 : bus.addr0;
                    din_d   = grantSel ? bus.din1  : bus.din0;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                cs[addr_q] = 1'b1;
                wStrobe    = we_q;
                rStrobe    = ~we_q;
                if (rStrobe) begin
                    dout_d = readWord;
                end
                state_d = DONE;
            end

            DONE: begin
                ack0    = ~sel_q;
                ack1    = sel_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and data registers. Reset aborts any transaction in flight and
    // clears the read data register; LAST comes out of reset pointing at
    // requester 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            last_q  <= 1'b1;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array. Only the selected word takes the write strobe, and a
    // reset landing on the ACCESS edge suppresses the write so the old cell
    // contents survive an aborted transaction. Reset never clears the array.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wStrobe && cs[i] && !rst_i) begin
                mem[i] <= din_q;
            end
        end
    end

    // Drive the completion side of the bus.
    always_comb begin
        bus.ack0 = ack0;
        bus.ack1 = ack1;
        bus.dout = dout_q;
        bus.busy = (state_q != IDLE);
    end

endmodule

// File: tb/tb_bin_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bin_ram_arbiter
//
// Directed bench for bin_ram_arbiter: reset values, write/read through both
// ports, reset during ACCESS, input changes while busy, and simultaneous
// requests (expected grant order depends on RAM_ARB_ROUND_ROBIN_EN).
// ----------------------------------------------------------------------------
module tb_bin_ram_arbiter;

    logic clk;
    logic rst;
    int   vectorCount;
    int   missCount;
    logic sawAck;

    bin_ram_arbiter_if #(.AW(2), .DW(4)) bus ();

    bin_ram_arbiter #(.AW(2), .DW(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle a little past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive both requester channels at once.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [1:0] a0,
                                 input logic [3:0] d0, input logic r1, input logic w1,
                                 input logic [1:0] a1, input logic [3:0] d1);
        bus.req0  = r0;
        bus.we0   = w0;
        bus.addr0 = a0;
        bus.din0  = d0;
        bus.req1  = r1;
        bus.we1   = w1;
        bus.addr1 = a1;
        bus.din1  = d1;
    endtask

    // One comparison: count it, and count and report it if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hold reset for two edges with no requests pending.
    task automatic doReset();
        applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Full single-requester write, checking the 3-cycle handshake timing.
    task automatic runWrite(input logic port, input logic [1:0] addr, input logic [3:0] data,
                            input string tag);
        if (port) applyStimulus(0, 0, 2'd0, 4'h0, 1, 1, addr, data);
        else      applyStimulus(1, 1, addr, data, 0, 0, 2'd0, 4'h0);
        tick();
        checkOutput({tag, "_busy_access"}, bus.busy, 1);
        checkOutput({tag, "_noack_access"}, {bus.ack0, bus.ack1}, 2'b00);
        tick();
        checkOutput({tag, "_ack_done"}, {bus.ack0, bus.ack1}, port ? 2'b01 : 2'b10);
        applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
        tick();
        checkOutput({tag, "_idle_after"}, {bus.busy, bus.ack0, bus.ack1}, 3'b000);
    endtask

    // Full single-requester read, checking ack and read data in DONE.
    task automatic runRead(input logic port, input logic [1:0] addr, input logic [3:0] expData,
                           input string tag);
        if (port) applyStimulus(0, 0, 2'd0, 4'h0, 1, 0, addr, 4'h0);
        else      applyStimulus(1, 0, addr, 4'h0, 0, 0, 2'd0, 4'h0);
        tick();
        checkOutput({tag, "_busy_access"}, bus.busy, 1);
        tick();
        checkOutput({tag, "_ack_done"}, {bus.ack0, bus.ack1}, port ? 2'b01 : 2'b10);
        checkOutput({tag, "_dout"}, bus.dout, expData);
        applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
        tick();
        checkOutput({tag, "_idle_after"}, {bus.busy, bus.ack0, bus.ack1}, 3'b000);
    endtask

    // Directed sequence of all test steps.
    initial begin
        logic [1:0] expAck [12];
        logic [3:0] expDout [12];
        vectorCount = 0;
        missCount   = 0;
        rst         = 1'b1;
        applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);

        // Reset values
        doReset();
        checkOutput("rst_ack0", bus.ack0, 0);
        checkOutput("rst_ack1", bus.ack1, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_dout", bus.dout, 4'h0);

        // Write A to addr 2 on port 0, read it back on port 1
        runWrite(0, 2'd2, 4'hA, "wr0_a2");
        runRead(1, 2'd2, 4'hA, "rd1_a2");

        // Preload remaining words for later steps
        runWrite(1, 2'd1, 4'h3, "wr1_a1");
        runWrite(0, 2'd0, 4'h7, "wr0_a0");
        runWrite(1, 2'd3, 4'hC, "wr1_a3");

        // Reset on the ACCESS edge of a write of 5 to addr 1
        applyStimulus(1, 1, 2'd1, 4'h5, 0, 0, 2'd0, 4'h0);
        tick();
        checkOutput("abort_busy_access", bus.busy, 1);
        rst = 1'b1;
        tick();
        checkOutput("abort_noack", {bus.ack0, bus.ack1}, 2'b00);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_dout", bus.dout, 4'h0);
        rst = 1'b0;
        applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
        tick();
        checkOutput("abort_noack_late", {bus.ack0, bus.ack1}, 2'b00);
        runRead(1, 2'd1, 4'h3, "abort_rd_a1");

        // Address change during ACCESS of a read is ignored
        applyStimulus(1, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
        tick();
        bus.addr0 = 2'd3;
        tick();
        checkOutput("chg_ack", {bus.ack0, bus.ack1}, 2'b10);
        checkOutput("chg_dout", bus.dout, 4'h7);
        applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
        tick();

        // Both requesters read continuously from reset (port0 addr0=7, port1 addr3=C)
        for (int i = 0; i < 12; i++) begin
            expAck[i]  = 2'b00;
            expDout[i] = 4'h0;
        end
`ifdef RAM_ARB_ROUND_ROBIN_EN
        expAck[1]  = 2'b10; expDout[1]  = 4'h7;
        expAck[4]  = 2'b01; expDout[4]  = 4'hC;
        expAck[7]  = 2'b10; expDout[7]  = 4'h7;
        expAck[10] = 2'b01; expDout[10] = 4'hC;
`else
        expAck[1]  = 2'b10; expDout[1]  = 4'h7;
        expAck[4]  = 2'b10; expDout[4]  = 4'h7;
        expAck[7]  = 2'b10; expDout[7]  = 4'h7;
        expAck[10] = 2'b10; expDout[10] = 4'h7;
`endif
        doReset();
        applyStimulus(1, 0, 2'd0, 4'h0, 1, 0, 2'd3, 4'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("both_ack_e%0d", i + 1), {bus.ack0, bus.ack1}, expAck[i]);
            if (expAck[i] != 2'b00) begin
                checkOutput($sformatf("both_dout_e%0d", i + 1), bus.dout, expDout[i]);
            end
        end

        // Drop requester 0; requester 1 must be acked within 3 cycles
        bus.req0 = 1'b0;
        sawAck   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!sawAck) begin
                tick();
                if (bus.ack1 === 1'b1) begin
                    sawAck = 1'b1;
                    checkOutput("drop0_dout", bus.dout, 4'hC);
                    checkOutput("drop0_no_ack0", bus.ack0, 0);
                end
            end
        end
        checkOutput("drop0_ack1_seen", sawAck, 1);
        applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
        tick();
        checkOutput("final_idle", {bus.busy, bus.ack0, bus.ack1}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/bin_ram_arbiter.md
# bin_ram_arbiter

Two-port arbiter and sequencer for a small word-organised RAM built from binary storage cells. Two requesters share one single-ported array through a req/ack handshake. The block chooses a winner, latches its command, and performs one read or one write. It then returns a one-cycle acknowledge with read data. It sits between bus-side masters (a CPU-style sequencer and a test/DMA engine) and the cell array, and owns the array's chip-select, read and write strobes.

## Interface
- AW, 2, address width; array depth 2^AW words
- DW, 4, data width in bits
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- REQ0, REQ1  in  1  request from requester 0 / 1
- WE0, WE1  in  1  1 = write, 0 = read; held with REQ
- ADDR0, ADDR1  in  AW  word address; held with REQ
- DIN0, DIN1  in  DW  write data; held with REQ
- ACK0, ACK1  out  1  one-cycle completion pulse to the served requester
- DOUT  out  DW  registered read data; valid while ACKk=1 for a read
- BUSY  out  1  high in any state other than IDLE

## Operation
- Storage: internal array of 2^AW words × DW bits. Each word has per-word CS, a shared R strobe and a shared W strobe, all driven only by this block. RST does not clear the array; cell contents are preserved.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if either REQ is high at the edge, pick a winner. Latch SEL, WE, ADDR and DIN of the winner, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: assert the CS of the latched address.
    - Write: assert W; mem[ADDR] <= DIN; DOUT holds its value.
    - Read: assert R; DOUT <= mem[ADDR].
    - Always go to DONE.
  - DONE: ACK[SEL]=1 (Moore, from state). Go to IDLE.
- Arbitration: a LAST register records the most recently served requester; its reset value is 1.
  - Only one REQ high: that requester wins.
  - Both high: winner per Configuration.
- Handshake: the requester holds REQ, WE, ADDR and DIN stable until it sees ACK. Inputs are sampled only in IDLE, so changes during ACCESS or DONE are ignored. REQ still high at the first IDLE edge after ACK is a new request.
- Outputs at reset: state=IDLE, ACK0=ACK1=0, BUSY=0, DOUT=0, LAST=1.
- RST mid-transaction (ACCESS or DONE): abort and return to IDLE with no ACK.
  - If RST coincides with the ACCESS edge, the write does not happen and DOUT is cleared to 0.
- Addresses always fall inside the array (full decode of AW bits); there is no out-of-range case.

## Timing
- Edge n, IDLE with REQk=1: latch command; ACCESS is active during cycle n..n+1.
- Edge n+1: memory access performed; DONE during cycle n+1..n+2. ACKk=1 and DOUT is valid in this cycle.
- Edge n+2: back to IDLE; the next request can be sampled at edge n+3.
- Throughput: one transaction per 3 cycles. ACK is never high for more than one cycle, and ACK0 and ACK1 are never high together.
- BUSY=1 from after edge n through edge n+2.

## Configuration
- Macro RAM_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters request, the winner is the one not equal to LAST. LAST updates on each grant. Neither requester can be starved.
- Undefined: fixed priority, REQ0 always beats REQ1. LAST is still maintained but not used.

## Test plan
- Reset: hold RST two cycles. Then ACK0=ACK1=0, BUSY=0, DOUT=4'h0.
- Write then read, single requester: REQ0 with WE0=1, ADDR0=2, DIN0=4'hA gives ACK0 two edges after sampling. Then REQ1 with WE1=0, ADDR1=2 gives ACK1 with DOUT=4'hA in the same cycle.
- Simultaneous requests, RAM_ARB_ROUND_ROBIN_EN defined: after reset, REQ0 and REQ1 held high continuously give the ACK order 0,1,0,1, each 3 cycles apart.
- Simultaneous requests, macro undefined: REQ0 and REQ1 held high give only ACK0 pulses. After REQ0 drops, ACK1 follows within 3 cycles.
- Reset mid-operation: start a write of 4'h5 to addr 1 (addr 1 previously held 4'h3) and assert RST on the ACCESS edge. No ACK is issued, and a later read of addr 1 returns 4'h3.
- Input change while busy: change ADDR0 from 0 to 3 during ACCESS of a read. DOUT equals mem[0], not mem[3].
